approximate_accuracy_controlable_multiplier: RTL and testbench
==============================================================

// Module: approximate_accuracy_controlable_multiplier
// PURPOSE
//   Iterative radix-2 shift-add unsigned multiplier with run-time accuracy control.
//   It is the inverse-operation companion of the approximate divider in the
//   approximate arithmetic unit set and sits in the execute stage beside it.
//   Accuracy trades precision for latency by skipping low-order multiplier bits.
//   Start/busy/done handshake; full 64-bit product returned as two 32-bit halves.
// PARAMETERS
//   WIDTH      32   operand width; product is 2*WIDTH bits
//   ACC_WIDTH   8   width of accuracy input
// PORTS
//   CLK          in   1      clock, rising edge
//   reset        in   1      asynchronous, active-high reset
//   start        in   1      request; sampled only in IDLE
//   input_1      in   32     multiplicand (unsigned)
//   input_2      in   32     multiplier (unsigned)
//   accuracy     in   8      k = number of low multiplier bits ignored (0 = exact)
//   busy         out  1      high while in MUL
//   done         out  1      one-cycle pulse: result valid
//   result       out  32     product[31:0]
//   result_high  out  32     product[63:32]
// BEHAVIOUR
//   Reset (async, any state): state=IDLE, busy=0, done=0, result=0, result_high=0,
//     internal product/counter/operand registers=0. Reset mid-MUL aborts; no done.
//   Operand latch: on the edge where state=IDLE and start=1: input_1, input_2 and
//     k=min(accuracy,32) captured; product cleared; bit index i=k.
//     Inputs may change afterwards without effect.
//   FSM:
//     IDLE -> MUL   start=1 and k<32
//     IDLE -> DONE  start=1 and k>=32 (product stays 0, zero MUL cycles)
//     MUL  -> MUL   i<31: if mplier[i] product += mcand<<i (64-bit, no overflow); i++
//     MUL  -> DONE  i==31: same add for bit 31
//     DONE -> IDLE  unconditionally
//   Latency: N=32-k MUL cycles. start sampled at edge 0 -> busy=1 for edges 1..N.
//     DONE state during cycle after edge N (done=1, busy=0).
//     k=32 gives done one cycle after start.
//   Outputs: result/result_high updated on entry to DONE.
//     Held stable until the next DONE or reset.
//   Approximation: product = input_1 * (input_2 & ~((1<<k)-1)).
//     k>=32 yields 0; accuracy values 32..255 are all treated as 32.
//   start while busy (MUL) or in DONE: ignored, no queuing.
//     New start accepted only in IDLE.
//   done is registered, exactly one cycle wide; busy and done never both 1.
//   Operand 0 on either input: normal iteration, product 0, no early exit.
// TESTING
//   7*6, acc=0 -> busy 32 cycles, done pulse, result=42, result_high=0.
//   0xFFFFFFFF*0xFFFFFFFF, acc=0 -> result=0x00000001, result_high=0xFFFFFFFE.
//   100*0x0F, acc=2 -> 30 busy cycles, result=1200 (100*0x0C), result_high=0.
//   5*9, acc=40 -> no busy, done on next cycle, result=0, result_high=0.
//   Start 3*4 acc=0. Pulse start with 9*9 at busy cycle 10 -> ignored; result=12.
//   Reset asserted at busy cycle 5 of 3*4 -> outputs 0 immediately, no done.
//     Fresh 3*4 afterwards -> 12.

Source files
------------

// File: rtl/approximate_accuracy_controlable_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : approximate_accuracy_controlable_multiplier
// Purpose  : Iterative radix-2 shift-add unsigned multiplier. A run-time
//            accuracy value k drops the k low-order multiplier bits from the
//            computation. Each dropped bit removes one iteration, so lower
//            accuracy gives a shorter latency.
// Ports    : CLK         - clock, rising edge
//            reset       - asynchronous active-high reset
//            start       - request; only sampled while idle
//            input_1     - multiplicand (unsigned, WIDTH bits)
//            input_2     - multiplier   (unsigned, WIDTH bits)
//            accuracy    - k, the number of low multiplier bits ignored
//            busy        - high while iterating
//            done        - one-cycle pulse, result valid
//            result      - product[WIDTH-1:0]
//            result_high - product[2*WIDTH-1:WIDTH]
// Revision : 1.0 - initial release
// ============================================================================
module approximate_accuracy_controlable_multiplier #(
    parameter int WIDTH     = 32,
    parameter int ACC_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     input_1,
    input  logic [WIDTH-1:0]     input_2,
    input  logic [ACC_WIDTH-1:0] accuracy,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     result,
    output logic [WIDTH-1:0]     result_high
);

    localparam int                   c_idx_w     = $clog2(WIDTH);
    localparam logic [c_idx_w-1:0]   c_last_idx  = c_idx_w'(WIDTH - 1);
    localparam logic [ACC_WIDTH-1:0] c_width_acc = ACC_WIDTH'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [WIDTH-1:0]       r_mcand;
    logic [WIDTH-1:0]       r_mplier;
    logic [2*WIDTH-1:0]     r_product;
    logic [c_idx_w-1:0]     r_idx;
    logic [WIDTH-1:0]       r_result;
    logic [WIDTH-1:0]       r_result_high;

    logic                   w_skip;
    logic                   w_last;
    logic [2*WIDTH-1:0]     w_addend;
    logic [2*WIDTH-1:0]     w_product_next;

    // Any accuracy of WIDTH or more ignores every multiplier bit: the product
    // is zero and the iteration phase is bypassed entirely.
    assign w_skip = (accuracy >= c_width_acc);
    assign w_last = (r_idx == c_last_idx);

    // Partial product for the current multiplier bit. The full double-width
    // accumulator means the sum can never overflow.
    assign w_addend       = r_mplier[r_idx] ? ({{WIDTH{1'b0}}, r_mcand} << r_idx)
                                            : {(2*WIDTH){1'b0}};
    assign w_product_next = r_product + w_addend;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = w_skip ? S_DONE : S_MUL;
                end
            end
            S_MUL: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand latch, accumulation and result capture
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_mcand       <= '0;
            r_mplier      <= '0;
            r_product     <= '0;
            r_idx         <= '0;
            r_result      <= '0;
            r_result_high <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand   <= input_1;
                        r_mplier  <= input_2;
                        r_product <= '0;
                        // Iteration begins at bit k; the skipped low bits
                        // are never examined.
                        r_idx     <= w_skip ? '0 : accuracy[c_idx_w-1:0];
                        if (w_skip) begin
                            r_result      <= '0;
                            r_result_high <= '0;
                        end
                    end
                end
                S_MUL: begin
                    r_product <= w_product_next;
                    r_idx     <= r_idx + 1'b1;
                    if (w_last) begin
                        r_result      <= w_product_next[WIDTH-1:0];
                        r_result_high <= w_product_next[2*WIDTH-1:WIDTH];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Status outputs decode directly from the state register, so both are
    // glitch-free registered values and mutually exclusive by construction.
    assign busy        = (r_state == S_MUL);
    assign done        = (r_state == S_DONE);
    assign result      = r_result;
    assign result_high = r_result_high;

endmodule
`default_nettype wire

// File: tb/tb_approximate_accuracy_controlable_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : tb_approximate_accuracy_controlable_multiplier
// Purpose  : Directed self-checking bench for the accuracy-controllable
//            shift-add multiplier, with hand-computed expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_approximate_accuracy_controlable_multiplier;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] input_1;
    logic [31:0] input_2;
    logic [7:0]  accuracy;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [31:0] result_high;

    int checks = 0;
    int errors = 0;

    approximate_accuracy_controlable_multiplier #(
        .WIDTH     (32),
        .ACC_WIDTH (8)
    ) u_dut (
        .CLK         (clk),
        .reset       (rst),
        .start       (start),
        .input_1     (input_1),
        .input_2     (input_2),
        .accuracy    (accuracy),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .result_high (result_high)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issues one operation and follows it to completion. Inputs are driven
    // on the falling edge and outputs sampled on the falling edge. If
    // pulse_at >= 0, a second start (9*9) is pulsed at that busy cycle.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [7:0] acc, input int exp_n,
                          input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                          input int pulse_at);
        int n;
        int guard;
        @(negedge clk);
        start    = 1'b1;
        input_1  = a;
        input_2  = b;
        accuracy = acc;
        @(negedge clk);
        start    = 1'b0;
        // Latched operands must not follow later input changes.
        input_1  = 32'hA5A5_5A5A;
        input_2  = 32'hFFFF_FFFF;
        accuracy = 8'd0;
        n     = 0;
        guard = 0;
        while (busy === 1'b1 && guard < 40) begin
            n++;
            if (done === 1'b1) check({tag, " busy_and_done"}, 64'd1, 64'd0);
            if (n == pulse_at) begin
                start   = 1'b1;
                input_1 = 32'd9;
                input_2 = 32'd9;
            end else begin
                start   = 1'b0;
            end
            @(negedge clk);
            guard++;
        end
        start = 1'b0;
        check({tag, " busy_cycles"}, 64'(n), 64'(exp_n));
        check({tag, " done"}, {63'd0, done}, 64'd1);
        check({tag, " product"}, {result_high, result}, {exp_hi, exp_lo});
        @(negedge clk);
        check({tag, " done_pulse_end"}, {62'd0, busy, done}, 64'd0);
        check({tag, " result_held"}, {result_high, result}, {exp_hi, exp_lo});
    endtask

    initial begin
        int n;
        rst      = 1'b1;
        start    = 1'b0;
        input_1  = '0;
        input_2  = '0;
        accuracy = '0;
        repeat (3) @(negedge clk);
        check("reset_state", {30'd0, busy, done, result}, 64'd0);
        check("reset_high",  {32'd0, result_high}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_reset", {62'd0, busy, done}, 64'd0);

        run_op("7x6",       32'd7,          32'd6,          8'd0,  32, 32'd42,         32'd0,          -1);
        run_op("max_sq",    32'hFFFF_FFFF,  32'hFFFF_FFFF,  8'd0,  32, 32'h0000_0001,  32'hFFFF_FFFE,  -1);
        run_op("100x15_k2", 32'd100,        32'h0000_000F,  8'd2,  30, 32'd1200,       32'd0,          -1);
        run_op("5x9_k40",   32'd5,          32'd9,          8'd40, 0,  32'd0,          32'd0,          -1);
        run_op("dead_k4",   32'hDEAD_BEEF,  32'h0000_001F,  8'd4,  28, 32'hEADB_EEF0,  32'h0000_000D,  -1);
        run_op("k31",       32'd3,          32'h8000_0001,  8'd31, 1,  32'h8000_0000,  32'h0000_0001,  -1);
        run_op("zero_mpl",  32'h1234_5678,  32'd0,          8'd0,  32, 32'd0,          32'd0,          -1);
        run_op("7x6_again", 32'd7,          32'd6,          8'd0,  32, 32'd42,         32'd0,          -1);
        run_op("k32",       32'hFFFF_FFFF,  32'hFFFF_FFFF,  8'd32, 0,  32'd0,          32'd0,          -1);
        run_op("zero_mcd",  32'd0,          32'h7777_7777,  8'd1,  31, 32'd0,          32'd0,          -1);
        run_op("k255",      32'd11,         32'hFFFF_FFFF,  8'd255, 0, 32'd0,          32'd0,          -1);
        run_op("ignored",   32'd3,          32'd4,          8'd0,  32, 32'd12,         32'd0,          10);
        check("no_restart", {62'd0, busy, done}, 64'd0);

        // Reset in the middle of an operation aborts it immediately.
        @(negedge clk);
        start    = 1'b1;
        input_1  = 32'd3;
        input_2  = 32'd4;
        accuracy = 8'd0;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 5) begin
            n++;
            if (n < 5) @(negedge clk);
        end
        check("pre_reset_busy", {63'd0, busy}, 64'd1);
        #1 rst = 1'b1;
        #1;
        check("async_reset_out", {30'd0, busy, done, result}, 64'd0);
        check("async_reset_hi",  {32'd0, result_high}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("no_done_after_abort", {62'd0, busy, done}, 64'd0);
        end
        run_op("fresh_3x4", 32'd3, 32'd4, 8'd0, 32, 32'd12, 32'd0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard bound on total simulation time.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
